// File: rtl/ysyx_23060191_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, FSM encoding and bus constants.
package ysyx_23060191_ifu_pkg;

    localparam int unsigned CPU_WIDTH = 32;

    // Fetch FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAr   = 2'd1,
        StR    = 2'd2,
        StOut  = 2'd3
    } ifu_state_e;

    // addi x0, x0, 0 -- substituted for any instruction that must not execute
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    // A fetch address is usable only when word aligned
    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060191_ifu.sv
// Instruction fetch unit: takes one PC per handshake, performs a single-beat AR/R read and
// hands a PC-tagged instruction (or a tagged error) to decode over valid/ready.
module ysyx_23060191_ifu
    import ysyx_23060191_ifu_pkg::*;
#(
    parameter int unsigned WIDTH = CPU_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    // PC unit side
    input  logic [WIDTH-1:0] pc,
    input  logic             pc_valid,
    output logic             pc_ready,
    input  logic             flush,
    // Instruction memory read channel
    output logic [WIDTH-1:0] araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    // Decode side
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             fetch_err,
    output logic             inst_valid,
    input  logic             inst_ready
);

    ifu_state_e       state_q;
    logic             drop_q;
    logic [WIDTH-1:0] araddr_q;
    logic             arvalid_q;
    logic             rready_q;
    logic [31:0]      inst_q;
    logic [WIDTH-1:0] inst_pc_q;
    logic             fetch_err_q;
    logic             accept;

    // Handshake signals decoded from state; flush blocks both directions for that cycle
    always_comb begin
        pc_ready   = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            StIdle: pc_ready = ~flush;
            StOut: begin
                pc_ready   = inst_ready & ~flush;
                inst_valid = ~flush;
            end
            default: ;
        endcase
    end

    assign accept = pc_valid & pc_ready;

    // Fetch FSM with registered bus and decode outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            drop_q      <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            fetch_err_q <= 1'b0;
        end else if (accept) begin
            // Reached from IDLE or from the OUT fast path; both start a new fetch
            araddr_q  <= pc;
            inst_pc_q <= pc;
            if (is_aligned(pc[1:0])) begin
                state_q   <= StAr;
                arvalid_q <= 1'b1;
            end else begin
                // Misaligned: skip the bus and report straight to decode
                state_q     <= StOut;
                inst_q      <= INST_NOP;
                fetch_err_q <= 1'b1;
            end
        end else begin
            case (state_q)
                StIdle: drop_q <= 1'b0;
                StAr: begin
                    // The address phase must complete even when flushed
                    if (flush) drop_q <= 1'b1;
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StR;
                    end
                end
                StR: begin
                    if (flush) drop_q <= 1'b1;
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        if (drop_q || flush) begin
                            state_q <= StIdle;
                            drop_q  <= 1'b0;
                        end else begin
                            inst_q      <= (rresp == RESP_OKAY) ? rdata : INST_NOP;
                            fetch_err_q <= (rresp != RESP_OKAY);
                            state_q     <= StOut;
                        end
                    end
                end
                StOut: begin
                    // Handshake with a new PC is handled by the accept branch above
                    if (flush || inst_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign inst      = inst_q;
    assign inst_pc   = inst_pc_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// Self-checking bench for ysyx_23060191_ifu: directed scenarios plus a randomized run
// against a transaction-level model of fetch, memory and flush behaviour.
module tb_ysyx_23060191_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic        inst_valid;
    logic        inst_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    ysyx_23060191_ifu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .flush      (flush),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fetch_err  (fetch_err),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory contents and response code as pure functions of the address
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        logic [4:0] w;
        w = a[6:2];
        return (w % 5 == 0) ? 2'b10 : 2'b00;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; pc = 32'h8000_0000; pc_valid = 1'b1; flush = 1'b0;
        arready = 1'b1; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; inst_ready = 1'b0;
        repeat (3) tick;
        n_tests++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
        n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b want 0", rready); end
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_err: got %b want 0", fetch_err); end
        n_tests++; if (araddr !== 32'h0) begin n_fail++; $display("FAIL rst_araddr: got %h want 0", araddr); end
        n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
        n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
        n_tests++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pc_ready: got %b want 1", pc_ready); end
        pc_valid = 1'b0;
        rstn = 1'b1;
        tick;
        n_tests++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_release_arvalid: got %b want 0", arvalid); end
    endtask

    task automatic test_basic;
        pc = 32'h8000_0000; pc_valid = 1'b1; arready = 1'b1; #1;
        n_tests++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL basic_pc_ready: got %b want 1", pc_ready); end
        tick; pc_valid = 1'b0; #1;
        n_tests++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_ar: got arvalid=%b araddr=%h want 1 80000000", arvalid, araddr); end
        tick; rvalid = 1'b1; rdata = 32'h0000_0297; rresp = 2'b00; #1;
        n_tests++; if (rready !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL basic_r: got rready=%b arvalid=%b want 1 0", rready, arvalid); end
        tick; rvalid = 1'b0; inst_ready = 1'b1; #1;
        n_tests++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0297 || inst_pc !== 32'h8000_0000 || fetch_err !== 1'b0)
            begin n_fail++; $display("FAIL basic_out: got v=%b inst=%h pc=%h err=%b want 1 00000297 80000000 0", inst_valid, inst, inst_pc, fetch_err); end
        tick; inst_ready = 1'b0; #1;
        n_tests++; if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got v=%b pc_ready=%b want 0 1", inst_valid, pc_ready); end
    endtask

    task automatic test_ar_wait;
        pc = 32'h8000_0004; pc_valid = 1'b1; arready = 1'b0;
        tick; pc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004 || pc_ready !== 1'b0 || rready !== 1'b0)
                begin n_fail++; $display("FAIL arwait_hold%0d: got arvalid=%b araddr=%h pc_ready=%b rready=%b want 1 80000004 0 0", i, arvalid, araddr, pc_ready, rready); end
            tick;
        end
        arready = 1'b1; #1;
        n_tests++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) begin n_fail++; $display("FAIL arwait_last: got arvalid=%b araddr=%h want 1 80000004", arvalid, araddr); end
        tick;
        n_tests++; if (rready !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL arwait_r: got rready=%b arvalid=%b want 1 0", rready, arvalid); end
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        tick; rvalid = 1'b0; inst_ready = 1'b1; #1;
        n_tests++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 32'h8000_0004)
            begin n_fail++; $display("FAIL arwait_out: got v=%b inst=%h pc=%h want 1 12345678 80000004", inst_valid, inst, inst_pc); end
        tick; inst_ready = 1'b0;
    endtask

    task automatic test_bus_err;
        pc = 32'h8000_000C; pc_valid = 1'b1; arready = 1'b1;
        tick; pc_valid = 1'b0;
        tick; rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rresp = 2'b10;
        tick; rvalid = 1'b0; rresp = 2'b00; #1;
        n_tests++; if (inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst !== NOP || inst_pc !== 32'h8000_000C)
            begin n_fail++; $display("FAIL buserr_out: got v=%b err=%b inst=%h pc=%h want 1 1 00000013 8000000c", inst_valid, fetch_err, inst, inst_pc); end
        inst_ready = 1'b1;
        tick; inst_ready = 1'b0;
    endtask

    task automatic test_misaligned;
        pc = 32'h8000_0002; pc_valid = 1'b1; arready = 1'b1;
        tick; pc_valid = 1'b0; #1;
        n_tests++; if (arvalid !== 1'b0 || inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst !== NOP || inst_pc !== 32'h8000_0002)
            begin n_fail++; $display("FAIL misal_out: got ar=%b v=%b err=%b inst=%h pc=%h want 0 1 1 00000013 80000002", arvalid, inst_valid, fetch_err, inst, inst_pc); end
        inst_ready = 1'b1;
        tick; inst_ready = 1'b0; #1;
        n_tests++; if (arvalid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL misal_after: got ar=%b v=%b want 0 0", arvalid, inst_valid); end
    endtask

    task automatic test_flush_r;
        pc = 32'h8000_0014; pc_valid = 1'b1; arready = 1'b1;
        tick; pc_valid = 1'b0;
        tick; flush = 1'b1; #1;
        n_tests++; if (pc_ready !== 1'b0 || rready !== 1'b1) begin n_fail++; $display("FAIL flushr_in_r: got pc_ready=%b rready=%b want 0 1", pc_ready, rready); end
        tick; flush = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick; rvalid = 1'b0; inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (inst_valid !== 1'b0 || pc_ready !== 1'b1 || arvalid !== 1'b0)
                begin n_fail++; $display("FAIL flushr_idle%0d: got v=%b pc_ready=%b ar=%b want 0 1 0", i, inst_valid, pc_ready, arvalid); end
            tick;
        end
        inst_ready = 1'b0;
        pc = 32'h8000_0010; pc_valid = 1'b1;
        tick; pc_valid = 1'b0; #1;
        n_tests++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010) begin n_fail++; $display("FAIL flushr_refetch_ar: got ar=%b addr=%h want 1 80000010", arvalid, araddr); end
        tick; rvalid = 1'b1; rdata = 32'h0010_0093; rresp = 2'b00;
        tick; rvalid = 1'b0; #1;
        n_tests++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0010 || fetch_err !== 1'b0)
            begin n_fail++; $display("FAIL flushr_refetch_out: got v=%b inst=%h pc=%h err=%b want 1 00100093 80000010 0", inst_valid, inst, inst_pc, fetch_err); end
        inst_ready = 1'b1;
        tick; inst_ready = 1'b0;
    endtask

    task automatic test_flush_out_idle;
        // Flush in IDLE blocks acceptance for that cycle
        pc = 32'h8000_0030; pc_valid = 1'b1; flush = 1'b1; #1;
        n_tests++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL flushidle_pc_ready: got %b want 0", pc_ready); end
        tick; #1;
        n_tests++; if (arvalid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL flushidle_noacc: got ar=%b v=%b want 0 0", arvalid, inst_valid); end
        // Reach OUT via misaligned PC, then flush it away
        flush = 1'b0; pc = 32'h8000_0021;
        tick; pc = 32'h8000_0020; flush = 1'b1; inst_ready = 1'b1; #1;
        n_tests++; if (inst_valid !== 1'b0 || pc_ready !== 1'b0) begin n_fail++; $display("FAIL flushout_block: got v=%b pc_ready=%b want 0 0", inst_valid, pc_ready); end
        tick; flush = 1'b0; pc_valid = 1'b0; #1;
        n_tests++; if (inst_valid !== 1'b0 || arvalid !== 1'b0 || pc_ready !== 1'b1)
            begin n_fail++; $display("FAIL flushout_idle: got v=%b ar=%b pc_ready=%b want 0 0 1", inst_valid, arvalid, pc_ready); end
        inst_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        pc = 32'h8000_0018; pc_valid = 1'b1; arready = 1'b1;
        tick; pc_valid = 1'b0;
        tick; rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b00;
        tick; rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001 || inst_pc !== 32'h8000_0018 || pc_ready !== 1'b0)
                begin n_fail++; $display("FAIL stall%0d: got v=%b inst=%h pc=%h pc_ready=%b want 1 cafe0001 80000018 0", i, inst_valid, inst, inst_pc, pc_ready); end
            tick;
        end
        inst_ready = 1'b1; pc = 32'h8000_0008; pc_valid = 1'b1; #1;
        n_tests++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL fast_pc_ready: got %b want 1", pc_ready); end
        tick; pc_valid = 1'b0; inst_ready = 1'b0; #1;
        n_tests++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0008 || inst_valid !== 1'b0)
            begin n_fail++; $display("FAIL fast_ar: got ar=%b addr=%h v=%b want 1 80000008 0", arvalid, araddr, inst_valid); end
        tick; rvalid = 1'b1; rdata = 32'hCAFE_0002; rresp = 2'b00;
        tick; rvalid = 1'b0; #1;
        n_tests++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0002 || inst_pc !== 32'h8000_0008)
            begin n_fail++; $display("FAIL fast_out: got v=%b inst=%h pc=%h want 1 cafe0002 80000008", inst_valid, inst, inst_pc); end
        inst_ready = 1'b1;
        tick; inst_ready = 1'b0;
    endtask

    // Model: every accepted PC yields exactly one tagged result unless a flush intervenes;
    // the memory answers each accepted address once with contents defined by mem_data/mem_resp.
    task automatic test_random;
        exp_t        q[$];
        exp_t        e;
        logic        rpend;
        logic [31:0] raddr_p;
        logic [31:0] ar_exp;
        logic [31:0] prev_araddr;
        logic        prev_ar_wait;
        logic [1:0]  r;
        int          wait_cnt;
        bit          drain;
        rpend = 1'b0; raddr_p = '0; ar_exp = '0; prev_araddr = '0; prev_ar_wait = 1'b0; wait_cnt = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            drain = (cyc >= 2300);
            if (drain) begin
                pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b1;
            end else begin
                pc_valid = ($urandom_range(2, 0) != 0);
                pc = $urandom;
                if ($urandom_range(5, 0) != 0) pc[1:0] = 2'b00;
                inst_ready = ($urandom_range(3, 0) != 0);
                flush = ($urandom_range(29, 0) == 0);
            end
            arready = $urandom_range(1, 0);
            if (rpend && (rvalid || $urandom_range(1, 0) == 1)) begin
                rvalid = 1'b1; rdata = mem_data(raddr_p); rresp = mem_resp(raddr_p);
            end else begin
                rvalid = 1'b0; rdata = $urandom; rresp = 2'b00;
            end
            #1;
            if (prev_ar_wait) begin
                n_tests++;
                if (arvalid !== 1'b1 || araddr !== prev_araddr) begin
                    n_fail++; $display("FAIL rand_ar_hold cyc%0d: got ar=%b addr=%h want 1 %h", cyc, arvalid, araddr, prev_araddr);
                end
            end
            if (inst_valid && inst_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious cyc%0d: got inst_valid=1 pc=%h want no instruction", cyc, inst_pc);
                end else begin
                    e = q.pop_front();
                    if (inst !== e.inst || inst_pc !== e.pc || fetch_err !== e.err) begin
                        n_fail++; $display("FAIL rand_out cyc%0d: got inst=%h pc=%h err=%b want %h %h %b", cyc, inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
                    end
                end
            end
            if (flush) q.delete();
            if (pc_valid && pc_ready) begin
                n_tests++;
                if (q.size() != 0) begin
                    n_fail++; $display("FAIL rand_overlap cyc%0d: got pc accepted with %0d pending want 0", cyc, q.size());
                end
                e.pc = pc;
                if (pc[1:0] != 2'b00) begin
                    e.inst = NOP; e.err = 1'b1;
                end else begin
                    ar_exp = pc;
                    r = mem_resp(pc);
                    e.err = (r != 2'b00);
                    e.inst = e.err ? NOP : mem_data(pc);
                end
                q.push_back(e);
            end
            if (arvalid && arready) begin
                n_tests++;
                if (araddr !== ar_exp || rpend) begin
                    n_fail++; $display("FAIL rand_ar cyc%0d: got addr=%h outstanding=%b want %h 0", cyc, araddr, rpend, ar_exp);
                end
                rpend = 1'b1; raddr_p = araddr;
            end
            if (rvalid && rready) rpend = 1'b0;
            prev_ar_wait = arvalid && !arready;
            prev_araddr = araddr;
            if (q.size() != 0) wait_cnt++; else wait_cnt = 0;
            if (wait_cnt > 100) begin
                n_tests++; n_fail++;
                $display("FAIL rand_timeout cyc%0d: got no result in 100 cycles want delivery", cyc);
                q.delete(); wait_cnt = 0;
            end
            tick;
        end
        n_tests++;
        if (q.size() != 0 || rpend) begin
            n_fail++; $display("FAIL rand_drain: got pending=%0d outstanding=%b want 0 0", q.size(), rpend);
        end
        pc_valid = 1'b0; inst_ready = 1'b0; rvalid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ar_wait();
        test_bus_err();
        test_misaligned();
        test_flush_r();
        test_flush_out_idle();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
